// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm unit: FSM encoding, BCD limits
// and the power-on alarm time.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] RST_HOUR = 8'h07;
  localparam logic [7:0] RST_MIN  = 8'h00;

endpackage

// File: rtl/alarm_unit_bcd_mod_inc.sv
// Combinational packed-BCD +1 that wraps to 00 once the value equals max_val.
module bcd_mod_inc (
  input  logic [7:0] val,
  input  logic [7:0] max_val,
  output logic [7:0] inc
);

  always_comb begin
    inc = 8'h00;
    if (val == max_val) begin
      inc = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      inc = {val[7:4] + 4'd1, 4'd0};
    end else begin
      inc = {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm clock stage: user-set BCD alarm time, time-match trigger and a
// RINGING/SNOOZE state machine driving a 1 s on / 1 s off gated tone.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int RING_S     = 60,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN_1HZ,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  input  logic       AL_EN,
  input  logic       SET,
  input  logic       H_UP,
  input  logic       M_UP,
  input  logic       SNOOZE,
  input  logic       STOP,
  input  logic       CP_TONE,
  output logic [7:0] A_H,
  output logic [7:0] A_M,
  output logic       RING,
  output logic       SNZ_ACT,
  output logic       AUDIO,
  output logic [1:0] dbg_state
);

  localparam int CNT_MAX = (RING_S > SNOOZE_S) ? RING_S : SNOOZE_S;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SW      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [CW-1:0] RING_LAST   = CW'(RING_S - 1);
  localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_S - 1);
  localparam logic [SW-1:0] SNZ_LIMIT   = SW'(MAX_SNOOZE);

  state_e        state, state_n;
  logic [CW-1:0] sec_cnt, sec_cnt_n;
  logic [SW-1:0] snz_cnt, snz_cnt_n;
  logic          beep_phase, beep_phase_n;
  logic [7:0]    h_inc, m_inc;
  logic          time_match;

  bcd_mod_inc u_hour_inc (
    .val     (A_H),
    .max_val (HOUR_MAX),
    .inc     (h_inc)
  );

  bcd_mod_inc u_min_inc (
    .val     (A_M),
    .max_val (MIN_MAX),
    .inc     (m_inc)
  );

  // Hour and minute are independent: no carry from minute wrap into hour.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      A_H <= RST_HOUR;
      A_M <= RST_MIN;
    end else if (SET) begin
      if (H_UP) A_H <= h_inc;
      if (M_UP) A_M <= m_inc;
    end
  end

  assign time_match = EN_1HZ && (Q_H == A_H) && (Q_M == A_M) && (Q_S == 8'h00);

  always_comb begin
    state_n      = state;
    sec_cnt_n    = sec_cnt;
    snz_cnt_n    = snz_cnt;
    beep_phase_n = beep_phase;
    if (!AL_EN || SET) begin
      state_n      = ST_IDLE;
      sec_cnt_n    = '0;
      snz_cnt_n    = '0;
      beep_phase_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (time_match) begin
            state_n      = ST_RINGING;
            sec_cnt_n    = '0;
            snz_cnt_n    = '0;
            beep_phase_n = 1'b1;
          end
        end
        ST_RINGING: begin
          // Buttons are checked before the 1 Hz timeout so they always win.
          if (STOP) begin
            state_n      = ST_IDLE;
            beep_phase_n = 1'b0;
          end else if (SNOOZE) begin
            if (snz_cnt < SNZ_LIMIT) begin
              state_n   = ST_SNOOZE;
              snz_cnt_n = snz_cnt + SW'(1);
              sec_cnt_n = '0;
            end else begin
              state_n      = ST_IDLE;
              beep_phase_n = 1'b0;
            end
          end else if (EN_1HZ) begin
            if (sec_cnt == RING_LAST) begin
              state_n      = ST_IDLE;
              beep_phase_n = 1'b0;
            end else begin
              sec_cnt_n    = sec_cnt + CW'(1);
              beep_phase_n = ~beep_phase;
            end
          end
        end
        ST_SNOOZE: begin
          if (STOP) begin
            state_n      = ST_IDLE;
            beep_phase_n = 1'b0;
          end else if (EN_1HZ) begin
            if (sec_cnt == SNOOZE_LAST) begin
              state_n      = ST_RINGING;
              sec_cnt_n    = '0;
              beep_phase_n = 1'b1;
            end else begin
              sec_cnt_n = sec_cnt + CW'(1);
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state      <= ST_IDLE;
      sec_cnt    <= '0;
      snz_cnt    <= '0;
      beep_phase <= 1'b0;
      RING       <= 1'b0;
      SNZ_ACT    <= 1'b0;
      AUDIO      <= 1'b0;
    end else begin
      state      <= state_n;
      sec_cnt    <= sec_cnt_n;
      snz_cnt    <= snz_cnt_n;
      beep_phase <= beep_phase_n;
      RING       <= (state_n == ST_RINGING);
      SNZ_ACT    <= (state_n == ST_SNOOZE);
      AUDIO      <= (state_n == ST_RINGING) && beep_phase_n && CP_TONE;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit with short ring/snooze periods.
module tb_alarm_unit;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       EN_1HZ = 1'b0;
  logic [7:0] Q_H = 8'h00;
  logic [7:0] Q_M = 8'h00;
  logic [7:0] Q_S = 8'h05;
  logic       AL_EN = 1'b0;
  logic       SET = 1'b0;
  logic       H_UP = 1'b0;
  logic       M_UP = 1'b0;
  logic       SNOOZE = 1'b0;
  logic       STOP = 1'b0;
  logic       CP_TONE = 1'b1;
  logic [7:0] A_H, A_M;
  logic       RING, SNZ_ACT, AUDIO;
  logic [1:0] dbg_state;

  int total = 0;
  int bad = 0;

  alarm_unit #(.RING_S(4), .SNOOZE_S(3), .MAX_SNOOZE(2)) dut (
    .CP(CP), .CR(CR), .EN_1HZ(EN_1HZ), .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
    .AL_EN(AL_EN), .SET(SET), .H_UP(H_UP), .M_UP(M_UP), .SNOOZE(SNOOZE),
    .STOP(STOP), .CP_TONE(CP_TONE), .A_H(A_H), .A_M(A_M), .RING(RING),
    .SNZ_ACT(SNZ_ACT), .AUDIO(AUDIO), .dbg_state(dbg_state)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: inputs settle, edge, then sample 1 time unit later.
  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic pulse_h(input int n);
    for (int i = 0; i < n; i++) begin
      H_UP = 1'b1; step(); H_UP = 1'b0;
    end
  endtask

  task automatic pulse_m(input int n);
    for (int i = 0; i < n; i++) begin
      M_UP = 1'b1; step(); M_UP = 1'b0;
    end
  endtask

  task automatic sec_tick();
    EN_1HZ = 1'b1; step(); EN_1HZ = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] mn);
    Q_H = 8'h07; Q_M = mn; Q_S = 8'h00;
    EN_1HZ = 1'b1; step(); EN_1HZ = 1'b0;
    Q_S = 8'h05;
  endtask

  task automatic press_snooze();
    SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic r, input logic s, input logic [1:0] st);
    chk({tag, "_ring"}, {7'b0, RING}, {7'b0, r});
    chk({tag, "_snz"}, {7'b0, SNZ_ACT}, {7'b0, s});
    chk({tag, "_st"}, {6'b0, dbg_state}, {6'b0, st});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ah", A_H, 8'h07);
    chk("rst_am", A_M, 8'h00);
    chk_state("rst", 1'b0, 1'b0, 2'd0);
    chk("rst_audio", {7'b0, AUDIO}, 8'h00);
    CR = 1'b0;
    step();

    // Alarm set with wrap at 23 and 59.
    SET = 1'b1;
    pulse_h(17);
    chk("set_h_wrap", A_H, 8'h00);
    pulse_m(61);
    chk("set_m_wrap", A_M, 8'h01);
    for (int i = 0; i < 7; i++) begin
      H_UP = 1'b1; M_UP = 1'b1; step(); H_UP = 1'b0; M_UP = 1'b0;
    end
    chk("set_both_h", A_H, 8'h07);
    chk("set_both_m", A_M, 8'h08);
    pulse_m(52);
    chk("set_m_back", A_M, 8'h00);
    SET = 1'b0;
    pulse_h(1);
    chk("set_ignored", A_H, 8'h07);

    // No false triggers.
    AL_EN = 1'b1;
    Q_H = 8'h07; Q_M = 8'h00; Q_S = 8'h01;
    sec_tick();
    chk_state("nf_sec01", 1'b0, 1'b0, 2'd0);
    SET = 1'b1;
    trigger(8'h00);
    chk_state("nf_set", 1'b0, 1'b0, 2'd0);
    SET = 1'b0;
    step();

    // Trigger and timeout; beep alternates each second.
    trigger(8'h00);
    chk_state("trig", 1'b1, 1'b0, 2'd1);
    chk("trig_audio", {7'b0, AUDIO}, 8'h01);
    CP_TONE = 1'b0; step();
    chk("tone_low", {7'b0, AUDIO}, 8'h00);
    CP_TONE = 1'b1;
    sec_tick();
    chk("beep_s1", {7'b0, AUDIO}, 8'h00);
    chk("ring_s1", {7'b0, RING}, 8'h01);
    sec_tick();
    chk("beep_s2", {7'b0, AUDIO}, 8'h01);
    sec_tick();
    chk("beep_s3", {7'b0, AUDIO}, 8'h00);
    chk("ring_s3", {7'b0, RING}, 8'h01);
    sec_tick();
    chk_state("timeout", 1'b0, 1'b0, 2'd0);
    chk("timeout_audio", {7'b0, AUDIO}, 8'h00);

    // Snooze cycling up to the limit.
    trigger(8'h00);
    press_snooze();
    chk_state("snz1", 1'b0, 1'b1, 2'd2);
    chk("snz1_audio", {7'b0, AUDIO}, 8'h00);
    sec_tick(); sec_tick();
    chk_state("snz1_wait", 1'b0, 1'b1, 2'd2);
    sec_tick();
    chk_state("snz1_back", 1'b1, 1'b0, 2'd1);
    chk("snz1_back_audio", {7'b0, AUDIO}, 8'h01);
    press_snooze();
    chk_state("snz2", 1'b0, 1'b1, 2'd2);
    press_snooze();
    chk_state("snz2_ignored", 1'b0, 1'b1, 2'd2);
    sec_tick(); sec_tick(); sec_tick();
    chk_state("snz2_back", 1'b1, 1'b0, 2'd1);
    press_snooze();
    chk_state("snz3_stop", 1'b0, 1'b0, 2'd0);

    // Priority cases.
    trigger(8'h00);
    STOP = 1'b1; SNOOZE = 1'b1; step(); STOP = 1'b0; SNOOZE = 1'b0;
    chk_state("stop_snz", 1'b0, 1'b0, 2'd0);
    trigger(8'h00);
    press_snooze();
    AL_EN = 1'b0; step();
    chk_state("alen_drop", 1'b0, 1'b0, 2'd0);
    chk("alen_audio", {7'b0, AUDIO}, 8'h00);
    AL_EN = 1'b1;
    trigger(8'h00);
    press_snooze();
    sec_tick(); sec_tick();
    STOP = 1'b1; EN_1HZ = 1'b1; step(); STOP = 1'b0; EN_1HZ = 1'b0;
    chk_state("stop_vs_tmo", 1'b0, 1'b0, 2'd0);
    trigger(8'h00);
    Q_S = 8'h00; STOP = 1'b1; EN_1HZ = 1'b1; step();
    STOP = 1'b0; EN_1HZ = 1'b0; Q_S = 8'h05;
    chk_state("stop_match", 1'b0, 1'b0, 2'd0);

    // Async reset mid-ringing.
    SET = 1'b1; pulse_m(1); SET = 1'b0;
    chk("am_01", A_M, 8'h01);
    trigger(8'h01);
    chk_state("pre_rst", 1'b1, 1'b0, 2'd1);
    #2 CR = 1'b1;
    #1;
    chk("arst_ah", A_H, 8'h07);
    chk("arst_am", A_M, 8'h00);
    chk("arst_ring", {7'b0, RING}, 8'h00);
    chk("arst_audio", {7'b0, AUDIO}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
